// File: rtl/ofb_stream_engine.sv
// rtl/ofb_stream_engine.sv - multi-block OFB engine driving an external block cipher
// Keystream chains KS[0]=E(IV), KS[n]=E(KS[n-1]); out = in ^ KS, so one datapath serves both directions.
module ofb_stream_engine #(
  parameter int BLK_W = 128,
  parameter int KEY_W = 128,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             bc_start,
  output logic [KEY_W-1:0] bc_key,
  output logic [BLK_W-1:0] bc_in,
  input  logic             bc_done,
  input  logic [BLK_W-1:0] bc_out
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_HAVE_KS, S_DRAIN} state_t;

  state_t           r_state;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_ks;
  logic             r_ks_valid;
  logic [CNT_W-1:0] r_remaining;
  logic             r_out_valid;
  logic [BLK_W-1:0] r_out_data;
  logic             r_out_last;
  logic             r_done;
  logic             r_bc_start;
  logic [BLK_W-1:0] r_bc_in;

  logic w_in_ready;
  logic w_xfer;
  logic w_out_accept;

  // A new block may enter only when the output register is free or being emptied this cycle.
  assign w_in_ready   = (r_state == S_HAVE_KS) && r_ks_valid && (!r_out_valid || out_ready);
  assign w_xfer       = in_valid && w_in_ready;
  assign w_out_accept = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key       <= '0;
      r_ks        <= '0;
      r_ks_valid  <= 1'b0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_bc_start  <= 1'b0;
      r_bc_in     <= '0;
    end else begin
      r_bc_start <= 1'b0;
      r_done     <= 1'b0;
      if (abort) begin
        r_state     <= S_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_ks_valid  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_key <= key;
              if (num_blocks == '0) begin
                r_done <= 1'b1;
              end else begin
                r_remaining <= num_blocks;
                r_bc_in     <= iv;
                r_bc_start  <= 1'b1;
                r_state     <= S_GEN;
              end
            end
          end
          S_GEN: begin
            // The previous block may still be waiting on the sink while the cipher runs.
            if (w_out_accept) r_out_valid <= 1'b0;
            if (bc_done) begin
              r_ks       <= bc_out;
              r_ks_valid <= 1'b1;
              r_state    <= S_HAVE_KS;
            end
          end
          S_HAVE_KS: begin
            if (w_xfer) begin
              r_out_data  <= in_data ^ r_ks;
              r_out_valid <= 1'b1;
              r_ks_valid  <= 1'b0;
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining > 1) begin
                r_bc_in    <= r_ks;
                r_bc_start <= 1'b1;
                r_state    <= S_GEN;
              end else begin
                r_out_last <= 1'b1;
                r_state    <= S_DRAIN;
              end
            end else if (w_out_accept) begin
              r_out_valid <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (w_out_accept) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign bc_start  = r_bc_start;
  assign bc_key    = r_key;
  assign bc_in     = r_bc_in;

endmodule

// File: tb/tb_ofb_stream_engine.sv
// tb/tb_ofb_stream_engine.sv - self-checking bench for ofb_stream_engine
// Stub cipher returns bc_in+1 three cycles after bc_start, so keystream block k is iv+k+1.
module tb_ofb_stream_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic [15:0]  num_blocks = '0;
  logic         busy;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_last;
  logic         done;
  logic         bc_start;
  logic [127:0] bc_key;
  logic [127:0] bc_in;
  logic         bc_done;
  logic [127:0] bc_out;

  ofb_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key), .iv(iv),
    .num_blocks(num_blocks), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done), .bc_start(bc_start), .bc_key(bc_key), .bc_in(bc_in),
    .bc_done(bc_done), .bc_out(bc_out)
  );

  always #5 clk = ~clk;

  logic [2:0]   stub_pipe;
  logic [127:0] stub_res;
  always @(posedge clk) begin
    if (!rst_n) begin
      stub_pipe <= '0;
      stub_res  <= '0;
    end else begin
      stub_pipe <= {stub_pipe[1:0], bc_start};
      if (bc_start) stub_res <= bc_in + 128'd1;
    end
  end
  assign bc_done = stub_pipe[2];
  assign bc_out  = stub_res;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [128:0] exp_q[$];
  logic [127:0] got_q[$];
  logic [127:0] bcin_q[$];
  logic [127:0] msg[16];
  int           dones = 0;
  logic         hold_chk = 1'b0;
  logic [127:0] hold_data = '0;
  logic         done_due = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
      done_due = 1'b0;
    end else begin
      if (bc_start) bcin_q.push_back(bc_in);
      if (done) dones++;
      if (done_due) check("done_after_last", {128'd0, done}, 129'd1);
      if (hold_chk) begin
        check("hold_valid", {128'd0, out_valid}, 129'd1);
        check("hold_data", {1'b0, out_data}, {1'b0, hold_data});
      end
      hold_chk  = out_valid && !out_ready;
      hold_data = out_data;
      done_due  = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          check("unexpected_out", {1'b0, out_data}, 129'h0);
        end else begin
          logic [128:0] e;
          e = exp_q.pop_front();
          check("out_data", {1'b0, out_data}, {1'b0, e[127:0]});
          check("out_last", {128'd0, out_last}, {128'd0, e[128]});
        end
      end
    end
  end

  // Reference: keystream k = iv + k + 1; output = data ^ keystream; bc_in k = iv + k.
  task automatic run_msg(input logic [127:0] m_iv, input int n, input int mode, input int restart_cyc);
    logic [127:0] ks;
    logic [127:0] m_key;
    int sent, cyc, d0, b0, g0, stall;
    ks = m_iv;
    for (int i = 0; i < n; i++) begin
      ks = ks + 128'd1;
      exp_q.push_back({(i == n - 1), msg[i] ^ ks});
    end
    m_key = {$urandom, $urandom, $urandom, $urandom};
    d0 = dones; b0 = bcin_q.size(); g0 = got_q.size();
    sent = 0; cyc = 0; stall = 10;
    @(posedge clk); #1;
    start = 1'b1; key = m_key; iv = m_iv; num_blocks = 16'(n);
    while (dones == d0 && cyc < 600) begin
      @(posedge clk); #1;
      start = (cyc == restart_cyc);
      if (start) begin
        iv = 128'h55; num_blocks = 16'd7; key = ~m_key;
      end
      in_valid = (sent < n);
      in_data  = (sent < n) ? msg[sent] : '0;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = !(got_q.size() - g0 == 1 && stall > 0);
          if (!out_ready) stall--;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); #1;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    check("msg_timeout", {128'd0, (cyc >= 600)}, 129'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 129'(dones - d0), 129'd1);
    check("bc_start_count", 129'(bcin_q.size() - b0), 129'(n));
    check("exp_drained", 129'(exp_q.size()), 129'd0);
    check("bc_key", {1'b0, bc_key}, {1'b0, m_key});
    for (int k = 0; k < n && b0 + k < bcin_q.size(); k++)
      check("bc_in_chain", {1'b0, bcin_q[b0 + k]}, {1'b0, m_iv + 128'(k)});
    check("idle_after", {128'd0, busy}, 129'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {128'd0, busy}, 129'd0);
    check({tag, "_in_ready"}, {128'd0, in_ready}, 129'd0);
    check({tag, "_out_valid"}, {128'd0, out_valid}, 129'd0);
    check({tag, "_out_data"}, {1'b0, out_data}, 129'd0);
    check({tag, "_out_last"}, {128'd0, out_last}, 129'd0);
    check({tag, "_done"}, {128'd0, done}, 129'd0);
    check({tag, "_bc_start"}, {128'd0, bc_start}, 129'd0);
    check({tag, "_bc_key"}, {1'b0, bc_key}, 129'd0);
    check({tag, "_bc_in"}, {1'b0, bc_in}, 129'd0);
  endtask

  initial begin
    int d0, b0, sent, cyc;
    logic [127:0] c0, c1, c2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Test 1: basic three-block encrypt
    msg[0] = 128'hA0; msg[1] = 128'hB0; msg[2] = 128'hC0;
    run_msg(128'h10, 3, 0, -1);
    c0 = got_q[got_q.size() - 3]; c1 = got_q[got_q.size() - 2]; c2 = got_q[got_q.size() - 1];
    check("t1_blk0", {1'b0, c0}, 129'hB1);
    check("t1_blk1", {1'b0, c1}, 129'hA2);
    check("t1_blk2", {1'b0, c2}, 129'hD3);

    // Test 2: sink stalls for 10 cycles after the first block
    run_msg(128'h10, 3, 1, -1);

    // Test 3: decrypt recovers the plaintext
    msg[0] = c0; msg[1] = c1; msg[2] = c2;
    run_msg(128'h10, 3, 0, -1);
    check("t3_blk0", {1'b0, got_q[got_q.size() - 3]}, 129'hA0);
    check("t3_blk2", {1'b0, got_q[got_q.size() - 1]}, 129'hC0);

    // Test 4: zero-length message
    b0 = bcin_q.size();
    @(posedge clk); #1 start = 1'b1; num_blocks = 16'd0; iv = 128'h77;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t4_done", {128'd0, done}, 129'd1);
    check("t4_busy", {128'd0, busy}, 129'd0);
    @(negedge clk);
    check("t4_done_pulse", {128'd0, done}, 129'd0);
    repeat (5) @(posedge clk);
    #1 check("t4_no_bc_start", 129'(bcin_q.size() - b0), 129'd0);

    // Test 5: abort during keystream generation for block 2
    msg[0] = 128'h1; msg[1] = 128'h2; msg[2] = 128'h3;
    exp_q.push_back({1'b0, msg[0] ^ 128'h11});
    d0 = dones; b0 = bcin_q.size(); sent = 0; cyc = 0;
    @(posedge clk); #1 start = 1'b1; iv = 128'h10; num_blocks = 16'd3;
    while (bcin_q.size() - b0 < 2 && cyc < 100) begin
      @(posedge clk); #1 start = 1'b0;
      in_valid = (sent < 3); in_data = msg[sent];
      @(negedge clk); #1;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("t5_reach_gen2", {128'd0, (cyc >= 100)}, 129'd0);
    @(posedge clk); #1 abort = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t5_busy", {128'd0, busy}, 129'd0);
    check("t5_out_valid", {128'd0, out_valid}, 129'd0);
    check("t5_in_ready", {128'd0, in_ready}, 129'd0);
    check("t5_bc_start", {128'd0, bc_start}, 129'd0);
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_done", 129'(dones - d0), 129'd0);
    check("t5_stray_ignored", {128'd0, busy}, 129'd0);
    exp_q.delete();
    @(posedge clk); #1 abort = 1'b1; start = 1'b1; num_blocks = 16'd2;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t5_abort_beats_start", {128'd0, busy}, 129'd0);
    msg[0] = 128'h0;
    run_msg(128'h20, 1, 0, -1);
    check("t5_ks_after_abort", {1'b0, got_q[got_q.size() - 1]}, 129'h21);

    // Test 6a: start while busy is ignored
    for (int i = 0; i < 4; i++) msg[i] = {$urandom, $urandom, $urandom, $urandom};
    run_msg(128'h300, 4, 0, 2);

    // Randomized messages, sink patterns and ivs
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) msg[i] = {$urandom, $urandom, $urandom, $urandom};
      run_msg({$urandom, $urandom, $urandom, $urandom}, n, $urandom_range(0, 2), -1);
    end

    // Test 6b: reset while a keystream block waits for input
    cyc = 0;
    @(posedge clk); #1 start = 1'b1; iv = 128'h40; num_blocks = 16'd2; key = 128'hABCD;
    @(posedge clk); #1 start = 1'b0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk); #1 cyc++;
    end
    check("t6_reach_have_ks", {128'd0, in_ready}, 129'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("t6_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    msg[0] = 128'h5;
    run_msg(128'h40, 1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
